zigzag_buffer: RTL and testbench

Reorders quantized 8×8 coefficient blocks from raster order into zigzag order for the entropy-coding stage. It sits directly downstream of the quantizer, consumes its `dataPort_t` stream, and feeds the run-length/entropy encoder. It uses a ping-pong pair of 64-entry banks so that one block fills while the previous block drains, with no backpressure at either side.

---
 rtl/zigzag_buffer_if.sv | 26 ++
 rtl/zigzag_buffer.sv | 144 ++++++++++++++
 tb/tb_zigzag_buffer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zigzag_buffer_if.sv
// Coefficient stream payload type and the bus interface of the zigzag reorder buffer.
package zigzag_pkg;
  localparam int unsigned COEF_WIDTH = 16;

  typedef struct packed {
    logic                  valid;
    logic [COEF_WIDTH-1:0] data;
  } dataPort_t;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_e;
endpackage

interface zigzag_buffer_if;
  import zigzag_pkg::*;

  dataPort_t in;
  dataPort_t out;
  logic      out_last;
  logic      overflow;

  modport master (output in, input out, out_last, overflow);
  modport slave  (input in, output out, out_last, overflow);
endinterface

// File: rtl/zigzag_buffer.sv
// Ping-pong 2x64 coefficient buffer: fills raster-order blocks, drains them in
// zigzag (or raster, for debug) order with a registered output stage.
module zigzag_buffer
  import zigzag_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = COEF_WIDTH,
  parameter bit          ZIGZAG     = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  zigzag_buffer_if.slave bus
);
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  // Raster index of each zigzag position.
  localparam logic [AW-1:0] ZZ_ROM [DEPTH] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [DATA_WIDTH-1:0] ram [2*DEPTH];

  logic            wr_bank;
  logic [AW-1:0]   wr_cnt;
  logic [1:0]      bank_full;
  logic            overflow;

  rd_state_e       state, state_nxt;
  logic            rd_bank, rd_bank_nxt;
  logic [AW-1:0]   rd_cnt, rd_cnt_nxt;

  logic                  out_valid;
  logic                  out_last;
  logic [DATA_WIDTH-1:0] out_data;

  logic            wr_en_c, wr_done_c, drop_c;
  logic            rd_en_c, rd_done_c;
  logic [1:0]      ready_c;
  logic [AW-1:0]   rd_addr_c;

  // Write-side qualification.
  always_comb begin
    wr_en_c   = bus.in.valid && !bank_full[wr_bank];
    wr_done_c = wr_en_c && (wr_cnt == LAST);
    drop_c    = bus.in.valid && bank_full[wr_bank];
  end

  // A bank completing this cycle counts as ready so back-to-back blocks drain without a bubble.
  always_comb begin
    ready_c = bank_full;
    if (wr_done_c) ready_c[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank  <= 1'b0;
      wr_cnt   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en_c) begin
        wr_cnt <= wr_cnt + AW'(1);
        if (wr_done_c) wr_bank <= ~wr_bank;
      end
      if (drop_c) overflow <= 1'b1;
    end
  end

  // Write side sets, read side clears; they never touch the same bank in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full <= '0;
    end else begin
      if (wr_done_c) bank_full[wr_bank] <= 1'b1;
      if (rd_done_c) bank_full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RD_IDLE;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      rd_bank <= rd_bank_nxt;
      rd_cnt  <= rd_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rd_bank_nxt = rd_bank;
    rd_cnt_nxt  = rd_cnt;
    rd_en_c     = 1'b0;
    rd_done_c   = 1'b0;
    case (state)
      RD_IDLE: begin
        if (ready_c[rd_bank]) state_nxt = RD_DRAIN;
      end
      RD_DRAIN: begin
        rd_en_c    = 1'b1;
        rd_cnt_nxt = rd_cnt + AW'(1);
        if (rd_cnt == LAST) begin
          rd_done_c   = 1'b1;
          rd_bank_nxt = ~rd_bank;
          if (!ready_c[~rd_bank]) state_nxt = RD_IDLE;
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  always_comb rd_addr_c = ZIGZAG ? ZZ_ROM[rd_cnt] : rd_cnt;

  always_ff @(posedge clk) begin
    if (wr_en_c) ram[{wr_bank, wr_cnt}] <= bus.in.data;
  end

  // The synchronous RAM read register doubles as the output data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= rd_en_c;
      out_last  <= rd_done_c;
      if (rd_en_c) out_data <= ram[{rd_bank, rd_addr_c}];
    end
  end

  assign bus.out      = '{valid: out_valid, data: out_data};
  assign bus.out_last = out_last;
  assign bus.overflow = overflow;

endmodule

// File: tb/tb_zigzag_buffer.sv
// Bench for zigzag_buffer: zigzag and raster instances share one stimulus and are
// checked every cycle against a block-level queue model, plus directed literal checks.
module tb_zigzag_buffer;
  import zigzag_pkg::*;

  logic      clk   = 1'b0;
  logic      rst_n = 1'b0;
  dataPort_t stim  = '0;
  bit        hold  = 1'b0;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int last_in = 0;

  always #5 clk = ~clk;

  zigzag_buffer_if bus_zz ();
  zigzag_buffer_if bus_rs ();
  assign bus_zz.in = stim;
  assign bus_rs.in = stim;

  zigzag_buffer #(.DATA_WIDTH(COEF_WIDTH), .ZIGZAG(1'b1)) dut_zz (
    .clk(clk), .rst_n(rst_n), .bus(bus_zz.slave));
  zigzag_buffer #(.DATA_WIDTH(COEF_WIDTH), .ZIGZAG(1'b0)) dut_rs (
    .clk(clk), .rst_n(rst_n), .bus(bus_rs.slave));

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Raster index of zigzag position k, found by walking the anti-diagonals.
  function automatic int zz_idx(input int k);
    int r = 0;
    int c = 0;
    for (int i = 0; i < k; i++) begin
      if (((r + c) % 2) == 0) begin
        if (c == 7) r++;
        else if (r == 0) c++;
        else begin r--; c++; end
      end else begin
        if (r == 7) c++;
        else if (c == 0) r++;
        else begin r++; c--; end
      end
    end
    return r * 8 + c;
  endfunction

  // Reference model: blocks complete after 64 accepted samples, at most two are held,
  // and a completed block streams out one coefficient per cycle starting the cycle after.
  logic [15:0] part [$];
  logic [15:0] rdyq [$];
  int          rdy_done [$];
  int          full_n    = 0;
  int          m_pos     = -1;
  bit          m_accept  = 1'b0;
  bit          hold_prev = 1'b0;
  bit          exp_valid = 1'b0;
  bit          exp_last  = 1'b0;
  bit          exp_ovf   = 1'b0;
  logic [15:0] exp_zz    = '0;
  logic [15:0] exp_rs    = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      part.delete();
      rdyq.delete();
      rdy_done.delete();
      full_n    = 0;
      m_pos     = -1;
      hold_prev = 1'b0;
      exp_valid = 1'b0;
      exp_last  = 1'b0;
      exp_ovf   = 1'b0;
    end else begin
      m_accept = stim.valid && (full_n < 2);
      if (stim.valid && !m_accept) exp_ovf = 1'b1;
      if (m_pos < 0 && rdy_done.size() > 0 && !hold_prev && rdy_done[0] < cyc) m_pos = 0;
      exp_valid = (m_pos >= 0);
      exp_last  = 1'b0;
      if (m_pos >= 0) begin
        exp_zz   = rdyq[zz_idx(m_pos)];
        exp_rs   = rdyq[m_pos];
        exp_last = (m_pos == 63);
        if (m_pos == 63) begin
          for (int i = 0; i < 64; i++) void'(rdyq.pop_front());
          void'(rdy_done.pop_front());
          full_n--;
          m_pos = -1;
        end else begin
          m_pos++;
        end
      end
      if (m_accept) begin
        part.push_back(stim.data);
        if (part.size() == 64) begin
          foreach (part[i]) rdyq.push_back(part[i]);
          part.delete();
          rdy_done.push_back(cyc);
          full_n++;
        end
      end
      hold_prev = hold;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("zz_valid", int'(bus_zz.out.valid), int'(exp_valid));
      check("rs_valid", int'(bus_rs.out.valid), int'(exp_valid));
      check("zz_ovf",   int'(bus_zz.overflow),  int'(exp_ovf));
      check("rs_ovf",   int'(bus_rs.overflow),  int'(exp_ovf));
      if (exp_valid) begin
        check("zz_data", int'(bus_zz.out.data), int'(exp_zz));
        check("rs_data", int'(bus_rs.out.data), int'(exp_rs));
        check("zz_last", int'(bus_zz.out_last), int'(exp_last));
        check("rs_last", int'(bus_rs.out_last), int'(exp_last));
      end
    end
  end

  logic [15:0] cap_zz   [256];
  logic [15:0] cap_rs   [256];
  bit          cap_last [256];
  int          cap_cyc  [256];
  int          cap_n = 0;

  task automatic send(input logic [15:0] d);
    stim.valid = 1'b1;
    stim.data  = d;
    last_in    = cyc;
    @(posedge clk); #1;
    stim.valid = 1'b0;
  endtask

  task automatic send_idle();
    stim.valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic collect(input string name, input int n, input int budget);
    int waited = 0;
    cap_n = 0;
    while (cap_n < n && waited < budget) begin
      @(negedge clk);
      waited++;
      if (bus_zz.out.valid) begin
        cap_zz[cap_n]   = bus_zz.out.data;
        cap_rs[cap_n]   = bus_rs.out.data;
        cap_last[cap_n] = bus_zz.out_last;
        cap_cyc[cap_n]  = cyc;
        cap_n++;
      end
    end
    check({name, "_count"}, cap_n, n);
  endtask

  function automatic int last_count();
    int nl = 0;
    for (int i = 0; i < cap_n; i++) nl += int'(cap_last[i]);
    return nl;
  endfunction

  task automatic check_idle_outputs(input string name);
    check({name, "_zz_valid"}, int'(bus_zz.out.valid), 0);
    check({name, "_zz_last"},  int'(bus_zz.out_last),  0);
    check({name, "_zz_ovf"},   int'(bus_zz.overflow),  0);
    check({name, "_zz_data"},  int'(bus_zz.out.data),  0);
    check({name, "_rs_valid"}, int'(bus_rs.out.valid), 0);
    check({name, "_rs_ovf"},   int'(bus_rs.overflow),  0);
  endtask

  task automatic check_ramp(input string name);
    int head [6] = '{0, 1, 8, 16, 9, 2};
    check({name, "_latency"}, cap_cyc[0] - last_in, 2);
    check({name, "_span"}, cap_cyc[63] - cap_cyc[0], 63);
    for (int i = 0; i < 6; i++) check({name, "_head"}, int'(cap_zz[i]), head[i]);
    check({name, "_zz61"}, int'(cap_zz[61]), 55);
    check({name, "_zz63"}, int'(cap_zz[63]), 63);
    check({name, "_rs37"}, int'(cap_rs[37]), 37);
    check({name, "_last63"}, int'(cap_last[63]), 1);
    check({name, "_nlast"}, last_count(), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_in;
    int sent;
    int nbad;

    #12;
    check_idle_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single raster ramp block.
    for (int i = 0; i < 64; i++) send(16'(i));
    collect("ramp", 64, 100);
    check_ramp("ramp");
    check("ramp_ovf", int'(bus_zz.overflow), 0);

    // Four back-to-back blocks, valid every cycle.
    first_in = cyc;
    fork
      for (int i = 0; i < 256; i++) send(16'(i));
      collect("b2b", 256, 400);
    join
    check("b2b_latency", cap_cyc[0] - first_in, 65);
    check("b2b_span", cap_cyc[255] - cap_cyc[0], 255);
    nbad = 0;
    for (int i = 0; i < 256; i++) if (cap_last[i] != ((i % 64) == 63)) nbad++;
    check("b2b_last_pos", nbad, 0);
    check("b2b_zz66", int'(cap_zz[66]), 72);
    check("b2b_zz130", int'(cap_zz[130]), 136);
    check("b2b_zz255", int'(cap_zz[255]), 255);

    // Sparse input, one valid every third cycle.
    for (int i = 0; i < 64; i++) begin
      if (i > 0) begin send_idle(); send_idle(); end
      send(16'(300 + i));
    end
    collect("sparse", 64, 100);
    check("sparse_latency", cap_cyc[0] - last_in, 2);
    check("sparse_span", cap_cyc[63] - cap_cyc[0], 63);
    check("sparse_zz3", int'(cap_zz[3]), 316);
    check("sparse_rs63", int'(cap_rs[63]), 363);

    // Read side held: third block overflows, first two drain intact afterwards.
    hold = 1'b1;
    force dut_zz.state = RD_IDLE;
    force dut_rs.state = RD_IDLE;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 64; i++) begin
        if (b == 2 && i == 0) check("ovf_before", int'(bus_zz.overflow), 0);
        send(16'(1000 + b * 64 + i));
        if (b == 2 && i == 0) check("ovf_first_drop", int'(bus_zz.overflow), 1);
      end
    end
    send_idle();
    release dut_zz.state;
    release dut_rs.state;
    hold = 1'b0;
    collect("ovf_drain", 128, 200);
    check("ovf_span", cap_cyc[127] - cap_cyc[0], 127);
    check("ovf_zz0", int'(cap_zz[0]), 1000);
    check("ovf_zz64", int'(cap_zz[64]), 1064);
    check("ovf_zz127", int'(cap_zz[127]), 1127);
    check("ovf_nlast", last_count(), 2);
    check("ovf_sticky", int'(bus_zz.overflow), 1);
    repeat (3) send_idle();

    // Reset asserted while output coefficient 20 is on the port.
    for (int i = 0; i < 64; i++) send(16'(i));
    collect("pre_reset", 21, 100);
    check("pre_reset_zz20", int'(cap_zz[20]), 40);
    #1 rst_n = 1'b0;
    #1 check_idle_outputs("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) send(16'(i));
    collect("post_reset", 64, 100);
    check_ramp("post_reset");

    // Random data with random gaps; the model checks every output cycle.
    sent = 0;
    fork
      begin
        while (sent < 320) begin
          if ($urandom_range(0, 3) != 0) begin
            send(16'($urandom));
            sent++;
          end else begin
            send_idle();
          end
        end
      end
      collect("rand", 256, 2000);
    join
    repeat (80) send_idle();
    check("rand_ovf", int'(bus_zz.overflow), 0);
    check("rand_idle", int'(bus_zz.out.valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
